// File: rtl/uart_frame_rx.sv
// Frame parser: hunts SOF, reads LEN, buffers the payload while feeding an external
// CRC-32 engine, checks the trailing CRC and releases the payload only on a match.
module uart_frame_rx #(
  parameter int         MAX_LEN        = 64,
  parameter logic [7:0] SOF_BYTE       = 8'hA5,
  parameter int         TIMEOUT_CYCLES = 100000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  input  logic [7:0]  in_data,
  output logic        crc_init,
  output logic        crc_en,
  output logic [7:0]  crc_data,
  input  logic [31:0] crc_value,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [7:0]  out_data,
  output logic        out_last,
  output logic        frame_ok,
  output logic        err_crc,
  output logic        err_len,
  output logic        err_timeout,
  output logic        err_overrun,
  output logic        busy
);

  localparam int            AW        = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;
  localparam int            TW        = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [TW-1:0] TMO_LAST  = TW'(TIMEOUT_CYCLES - 1);
  localparam logic [7:0]    MAX_LEN_B = 8'(MAX_LEN);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_LEN     = 3'd1,
    S_PAYLOAD = 3'd2,
    S_CRC     = 3'd3,
    S_CHECK   = 3'd4,
    S_DRAIN   = 3'd5
  } state_t;

  state_t        r_state, w_next;
  logic [7:0]    r_len, r_idx, r_rd_idx;
  logic [1:0]    r_crc_cnt;
  logic [31:0]   r_rx_crc;
  logic [TW-1:0] r_tmo;
  logic [7:0]    r_buf [0:(1<<AW)-1];
  logic          r_out_valid, r_out_last, r_frame_ok, r_err_crc, r_err_len;
  logic          r_err_timeout, r_err_overrun, r_busy;
  logic [7:0]    r_out_data;

  logic          w_crc_init, w_crc_en, w_err_len, w_done_crc, w_overrun;
  logic [7:0]    w_crc_data;
  logic          w_active, w_len_bad, w_pay_last, w_crc_last, w_crc_match, w_tmo_hit;
  logic          w_handshake;
  logic [7:0]    w_rd_nxt;

  assign w_active    = (r_state == S_LEN) || (r_state == S_PAYLOAD) || (r_state == S_CRC);
  assign w_len_bad   = (in_data == 8'd0) || (in_data > MAX_LEN_B);
  assign w_pay_last  = (r_idx == (r_len - 8'd1));
  assign w_crc_last  = (r_crc_cnt == 2'd3);
  // Compare against the word the 4th CRC byte completes; the engine settled long before.
  assign w_crc_match = ({in_data, r_rx_crc[31:8]} == ~crc_value);
  assign w_tmo_hit   = w_active && !in_valid && (r_tmo == TMO_LAST);
  assign w_handshake = r_out_valid && out_ready;
  assign w_rd_nxt    = r_rd_idx + 8'd1;

  // State register
  always_ff @(posedge clk) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_next;
  end

  // Next-state logic
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:    w_next = (in_valid && (in_data == SOF_BYTE)) ? S_LEN : S_IDLE;
      S_LEN: begin
        if (w_tmo_hit)     w_next = S_IDLE;
        else if (in_valid) w_next = w_len_bad ? S_IDLE : S_PAYLOAD;
        else               w_next = S_LEN;
      end
      S_PAYLOAD: begin
        if (w_tmo_hit)                   w_next = S_IDLE;
        else if (in_valid && w_pay_last) w_next = S_CRC;
        else                             w_next = S_PAYLOAD;
      end
      S_CRC: begin
        if (w_tmo_hit)                   w_next = S_IDLE;
        else if (in_valid && w_crc_last) w_next = S_CHECK;
        else                             w_next = S_CRC;
      end
      S_CHECK:   w_next = r_frame_ok ? S_DRAIN : S_IDLE;
      S_DRAIN:   w_next = (w_handshake && r_out_last) ? S_IDLE : S_DRAIN;
      default:   w_next = S_IDLE;
    endcase
  end

  // Output decode: CRC engine controls and per-byte event strobes
  always_comb begin
    w_crc_init = 1'b0;
    w_crc_en   = 1'b0;
    w_crc_data = 8'h00;
    w_err_len  = 1'b0;
    w_done_crc = 1'b0;
    w_overrun  = 1'b0;
    case (r_state)
      S_IDLE:    w_crc_init = in_valid && (in_data == SOF_BYTE);
      S_LEN:     w_err_len  = in_valid && w_len_bad;
      S_PAYLOAD: begin
        w_crc_en   = in_valid;
        w_crc_data = in_valid ? in_data : 8'h00;
      end
      S_CRC:     w_done_crc = in_valid && w_crc_last;
      S_CHECK,
      S_DRAIN:   w_overrun  = in_valid;
      default:   w_crc_init = 1'b0;
    endcase
  end

  // Counters, received CRC, drain output register and registered status strobes
  always_ff @(posedge clk) begin
    if (rst) begin
      r_len         <= 8'd0;
      r_idx         <= 8'd0;
      r_rd_idx      <= 8'd0;
      r_crc_cnt     <= 2'd0;
      r_rx_crc      <= 32'd0;
      r_tmo         <= '0;
      r_out_valid   <= 1'b0;
      r_out_data    <= 8'h00;
      r_out_last    <= 1'b0;
      r_frame_ok    <= 1'b0;
      r_err_crc     <= 1'b0;
      r_err_len     <= 1'b0;
      r_err_timeout <= 1'b0;
      r_err_overrun <= 1'b0;
      r_busy        <= 1'b0;
    end else begin
      r_frame_ok    <= w_done_crc && w_crc_match;
      r_err_crc     <= w_done_crc && !w_crc_match;
      r_err_len     <= w_err_len;
      r_err_timeout <= w_tmo_hit;
      r_err_overrun <= w_overrun;
      r_busy        <= (w_next != S_IDLE);
      r_tmo         <= (in_valid || !w_active) ? '0 : r_tmo + TW'(1);
      case (r_state)
        S_IDLE: begin
          r_idx     <= 8'd0;
          r_crc_cnt <= 2'd0;
        end
        S_LEN:     if (in_valid) r_len <= in_data;
        S_PAYLOAD: if (in_valid) r_idx <= w_pay_last ? 8'd0 : r_idx + 8'd1;
        S_CRC: begin
          if (in_valid) begin
            r_rx_crc  <= {in_data, r_rx_crc[31:8]};
            r_crc_cnt <= r_crc_cnt + 2'd1;
          end
        end
        S_CHECK: begin
          if (r_frame_ok) begin
            r_out_valid <= 1'b1;
            r_out_data  <= r_buf[0];
            r_out_last  <= (r_len == 8'd1);
            r_rd_idx    <= 8'd0;
          end
        end
        S_DRAIN: begin
          if (w_handshake) begin
            if (r_out_last) begin
              r_out_valid <= 1'b0;
              r_out_last  <= 1'b0;
            end else begin
              r_rd_idx   <= w_rd_nxt;
              r_out_data <= r_buf[w_rd_nxt[AW-1:0]];
              r_out_last <= (w_rd_nxt == (r_len - 8'd1));
            end
          end
        end
        default: r_idx <= 8'd0;
      endcase
    end
  end

  // Payload buffer, left without reset so it maps onto plain storage
  always_ff @(posedge clk) begin
    if ((r_state == S_PAYLOAD) && in_valid) r_buf[r_idx[AW-1:0]] <= in_data;
  end

  assign crc_init    = w_crc_init;
  assign crc_en      = w_crc_en;
  assign crc_data    = w_crc_data;
  assign out_valid   = r_out_valid;
  assign out_data    = r_out_data;
  assign out_last    = r_out_last;
  assign frame_ok    = r_frame_ok;
  assign err_crc     = r_err_crc;
  assign err_len     = r_err_len;
  assign err_timeout = r_err_timeout;
  assign err_overrun = r_err_overrun;
  assign busy        = r_busy;

endmodule

// File: tb/tb_uart_frame_rx.sv
// Bench for uart_frame_rx: a behavioural reflected CRC-32 engine on the crc_* ports,
// a table of whole frames, and directed sequences for timeout, overrun and reset.
module tb_uart_frame_rx;

  localparam int TMO = 50;

  logic        clk = 1'b0;
  logic        rst, in_valid, out_ready;
  logic [7:0]  in_data;
  logic        crc_init, crc_en, out_valid, out_last, frame_ok;
  logic        err_crc, err_len, err_timeout, err_overrun, busy;
  logic [7:0]  crc_data, out_data;
  logic [31:0] crc_value;

  uart_frame_rx #(.MAX_LEN(64), .SOF_BYTE(8'hA5), .TIMEOUT_CYCLES(TMO)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_data(in_data),
    .crc_init(crc_init), .crc_en(crc_en), .crc_data(crc_data), .crc_value(crc_value),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_last(out_last),
    .frame_ok(frame_ok), .err_crc(err_crc), .err_len(err_len), .err_timeout(err_timeout),
    .err_overrun(err_overrun), .busy(busy)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] crc_step(input logic [31:0] c, input logic [7:0] d);
    logic [31:0] x;
    x = c ^ {24'd0, d};
    for (int b = 0; b < 8; b++) x = x[0] ? ((x >> 1) ^ 32'hEDB88320) : (x >> 1);
    return x;
  endfunction

  always @(posedge clk) begin
    if (rst || crc_init) crc_value <= 32'hFFFFFFFF;
    else if (crc_en)     crc_value <= crc_step(crc_value, crc_data);
  end

  int checks = 0, failures = 0;
  int n_ok, n_crc, n_len, n_tmo, n_ovr, n_ov, n_last, last_idx;
  logic [7:0] got[$];
  logic stall_prev = 1'b0, stall_last;
  logic [7:0] stall_data;
  int ready_mode = 0, rcnt = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Event monitor: pulse counters, handshake capture, hold-while-stalled checks.
  always @(negedge clk) begin
    if (!rst) begin
      n_ok  += int'(frame_ok);
      n_crc += int'(err_crc);
      n_len += int'(err_len);
      n_tmo += int'(err_timeout);
      n_ovr += int'(err_overrun);
      n_ov  += int'(out_valid);
      chk("crc_init_en_excl", {31'd0, crc_init && crc_en}, 32'd0);
      chk("err_excl", 32'(int'(err_crc) + int'(err_len) + int'(err_timeout)) <= 32'd1 ? 32'd1 : 32'd0, 32'd1);
      if (stall_prev && out_valid) chk("stall_hold", {23'd0, out_last, out_data}, {23'd0, stall_last, stall_data});
      if (out_valid && out_ready) begin
        got.push_back(out_data);
        if (out_last) begin
          n_last++;
          last_idx = got.size() - 1;
        end
      end
      stall_prev = out_valid && !out_ready;
      stall_data = out_data;
      stall_last = out_last;
    end else begin
      stall_prev = 1'b0;
    end
  end

  initial begin
    out_ready = 1'b1;
    forever begin
      @(posedge clk); #1;
      rcnt++;
      out_ready = (ready_mode == 0) || (rcnt % 3 == 0);
    end
  end

  task automatic clr_mon();
    n_ok = 0; n_crc = 0; n_len = 0; n_tmo = 0; n_ovr = 0; n_ov = 0; n_last = 0; last_idx = -1;
    got.delete();
  endtask

  task automatic put(input logic [7:0] b);
    in_valid = 1'b1;
    in_data  = b;
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic send_stream(input logic [159:0] s, input int n);
    for (int k = 0; k < n; k++) put(s[8*(n-1-k) +: 8]);
  endtask

  task automatic wait_idle(input string nm);
    int k = 0;
    while (busy && k < 300) begin
      @(posedge clk); #1;
      k++;
    end
    chk({nm, "_idle_bound"}, {31'd0, busy}, 32'd0);
    repeat (2) begin @(posedge clk); #1; end
  endtask

  task automatic check_result(input string nm, input int e_ok, input int e_crc, input int e_len,
                              input int e_tmo, input int e_ovr, input int e_n, input logic [71:0] e_d);
    chk({nm, "_frame_ok"}, n_ok, e_ok);
    chk({nm, "_err_crc"}, n_crc, e_crc);
    chk({nm, "_err_len"}, n_len, e_len);
    chk({nm, "_err_timeout"}, n_tmo, e_tmo);
    chk({nm, "_err_overrun"}, n_ovr, e_ovr);
    chk({nm, "_nbytes"}, got.size(), e_n);
    if (e_n == 0) chk({nm, "_no_out_valid"}, n_ov, 0);
    else begin
      chk({nm, "_last_pos"}, last_idx, e_n - 1);
      chk({nm, "_last_cnt"}, n_last, 1);
    end
    for (int k = 0; k < e_n && k < got.size(); k++)
      chk($sformatf("%s_byte%0d", nm, k), {24'd0, got[k]}, {24'd0, e_d[8*(e_n-1-k) +: 8]});
    chk({nm, "_out_valid_end"}, {31'd0, out_valid}, 32'd0);
  endtask

  typedef struct packed {
    logic [159:0] stream;
    int           n;
    int           e_ok;
    int           e_crc;
    int           e_len;
    int           e_nout;
    logic [71:0]  e_data;
  } vec_t;

  vec_t vecs[6];

  task automatic run_vec(input int i);
    clr_mon();
    send_stream(vecs[i].stream, vecs[i].n);
    wait_idle($sformatf("vec%0d", i));
    check_result($sformatf("vec%0d", i), vecs[i].e_ok, vecs[i].e_crc, vecs[i].e_len, 0, 0,
                 vecs[i].e_nout, vecs[i].e_data);
  endtask

  initial begin
    vecs[0] = '{160'hA509313233343536373839_2639F4CB, 15, 1, 0, 0, 9, 72'h313233343536373839};
    vecs[1] = '{160'hA509313233343536373839_2639F4CA, 15, 0, 1, 0, 0, 72'h0};
    vecs[2] = '{160'hA500, 2, 0, 0, 1, 0, 72'h0};
    vecs[3] = '{160'hA541, 2, 0, 0, 1, 0, 72'h0};
    vecs[4] = '{160'h1122A509313233343536373839_2639F4CB, 17, 1, 0, 0, 9, 72'h313233343536373839};
    vecs[5] = '{160'hA50161_43BEB7E8, 7, 1, 0, 0, 1, 72'h61};

    rst = 1'b1; in_valid = 1'b0; in_data = 8'h00;
    clr_mon();
    repeat (3) @(posedge clk);
    #1;
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
    chk("rst_pulses", {26'd0, frame_ok, err_crc, err_len, err_timeout, err_overrun, out_last}, 32'd0);
    chk("rst_crc_ctl", {22'd0, crc_init, crc_en, crc_data}, 32'd0);
    rst = 1'b0;
    @(posedge clk); #1;

    in_valid = 1'b1; in_data = 8'hA5; #1;
    chk("sof_crc_init", {30'd0, crc_init, crc_en}, 32'd2);
    in_valid = 1'b0; in_data = 8'h00;
    rst = 1'b1; @(posedge clk); #1; rst = 1'b0; @(posedge clk); #1;

    for (int i = 0; i < 6; i++) run_vec(i);

    // LEN equal to MAX_LEN is legal; the all-zero CRC field then cannot match
    clr_mon();
    put(8'hA5); put(8'h40);
    for (int k = 0; k < 68; k++) put(8'h00);
    wait_idle("len64");
    check_result("len64", 0, 1, 0, 0, 0, 0, 72'h0);

    // Inter-byte timeout fires exactly TMO cycles after the last byte
    clr_mon();
    send_stream(160'hA50931323334, 6);
    repeat (TMO - 1) begin @(posedge clk); #1; end
    chk("tmo_before_busy", {31'd0, busy}, 32'd1);
    chk("tmo_before_pulse", {31'd0, err_timeout}, 32'd0);
    @(posedge clk); #1;
    chk("tmo_pulse", {31'd0, err_timeout}, 32'd1);
    chk("tmo_busy", {31'd0, busy}, 32'd0);
    @(posedge clk); #1;
    chk("tmo_pulse_one", {31'd0, err_timeout}, 32'd0);
    chk("tmo_count", n_tmo, 1);
    run_vec(0);

    // Slow consumer plus two bytes injected during CHECK and DRAIN
    clr_mon();
    ready_mode = 1;
    send_stream(vecs[0].stream, vecs[0].n);
    put(8'hA5);
    repeat (3) begin @(posedge clk); #1; end
    put(8'h77);
    wait_idle("ovr");
    check_result("ovr", 1, 0, 0, 0, 2, 9, 72'h313233343536373839);
    ready_mode = 0;

    // Reset in the middle of a payload
    send_stream(160'hA509313233, 5);
    rst = 1'b1; @(posedge clk); #1;
    chk("rst_pay_busy", {31'd0, busy}, 32'd0);
    chk("rst_pay_ov", {31'd0, out_valid}, 32'd0);
    rst = 1'b0;
    run_vec(0);

    // Reset in the middle of a drain
    ready_mode = 1;
    send_stream(vecs[0].stream, vecs[0].n);
    for (int k = 0; k < 5; k++) begin @(posedge clk); #1; end
    chk("drain_active", {31'd0, out_valid}, 32'd1);
    rst = 1'b1; @(posedge clk); #1;
    chk("rst_drain_busy", {31'd0, busy}, 32'd0);
    chk("rst_drain_ov", {31'd0, out_valid}, 32'd0);
    rst = 1'b0;
    ready_mode = 0;
    @(posedge clk); #1;
    run_vec(0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
